// File: rtl/game_pkg.sv
// Shared definitions for the wall map: field geometry, game state codes,
// map controller states and the fixed wall layout.
package game_pkg;

   localparam int MAP_W    = 64;
   localparam int MAP_H    = 44;
   localparam int WQ_DEPTH = 4;
   localparam int COORD_W  = 6;

   // Game state codes driven by the top-level game controller
   localparam logic [1:0] ST_START = 2'b00;
   localparam logic [1:0] ST_GAME  = 2'b01;
   localparam logic [1:0] ST_OVER  = 2'b10;
   localparam logic [1:0] ST_TEST  = 2'b11;

   // Coordinate limits in the 6-bit coordinate width. Every 6-bit x is
   // inside the 64-wide field, so only y can be out of range.
   localparam logic [COORD_W-1:0] X_LAST  = COORD_W'(MAP_W - 1);
   localparam logic [COORD_W-1:0] Y_LAST  = COORD_W'(MAP_H - 1);
   localparam logic [COORD_W-1:0] Y_LIMIT = COORD_W'(MAP_H);

   typedef enum logic [1:0] {
      MAP_IDLE,
      MAP_INIT,
      MAP_RUN
   } map_state_t;

   // Outer frame plus short vertical pillars every 8 columns
   function automatic logic is_layout_wall(input logic [COORD_W-1:0] x,
                                           input logic [COORD_W-1:0] y);
      return (x == '0) || (x == X_LAST) || (y == '0) || (y == Y_LAST) ||
             ((x[2:0] == 3'd4) && (y[2:0] >= 3'd2) && (y[2:0] <= 3'd5));
   endfunction

   // Frame cells are indestructible
   function automatic logic is_border(input logic [COORD_W-1:0] x,
                                      input logic [COORD_W-1:0] y);
      return (x == '0) || (x == X_LAST) || (y == '0) || (y == Y_LAST);
   endfunction

endpackage

// File: rtl/wall_write_fifo.sv
// Small queue of pending wall-destroy coordinates. Besides push/pop it
// reports whether a given cell is still waiting in the queue, so game-side
// reads can see a destroy before it is committed to the bitmap.
module wall_write_fifo
   import game_pkg::*;
#(
   parameter int DEPTH = WQ_DEPTH
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_flush,
   input  logic               i_push,
   input  logic [COORD_W-1:0] i_push_x,
   input  logic [COORD_W-1:0] i_push_y,
   input  logic               i_pop,
   output logic [COORD_W-1:0] o_pop_x,
   output logic [COORD_W-1:0] o_pop_y,
   output logic               o_full,
   output logic               o_empty,
   input  logic [COORD_W-1:0] i_match_x,
   input  logic [COORD_W-1:0] i_match_y,
   output logic               o_match
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [COORD_W-1:0] r_entryX [DEPTH];
   logic [COORD_W-1:0] r_entryY [DEPTH];
   logic [DEPTH-1:0]   r_entryValid;
   logic [AW-1:0]      r_wrPtr;
   logic [AW-1:0]      r_rdPtr;
   logic [CW-1:0]      r_count;
   logic               w_doPush;
   logic               w_doPop;
   logic               w_match;

   assign o_full   = (r_count == CW'(DEPTH));
   assign o_empty  = (r_count == '0);
   assign w_doPush = i_push & ~o_full;
   assign w_doPop  = i_pop & ~o_empty;
   assign o_pop_x  = r_entryX[r_rdPtr];
   assign o_pop_y  = r_entryY[r_rdPtr];
   assign o_match  = w_match;

   // Queue storage and pointers; a flush drops every pending entry at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_entryX[i] <= '0;
            r_entryY[i] <= '0;
         end
         r_entryValid <= '0;
         r_wrPtr      <= '0;
         r_rdPtr      <= '0;
         r_count      <= '0;
      end else if (i_flush) begin
         r_entryValid <= '0;
         r_wrPtr      <= '0;
         r_rdPtr      <= '0;
         r_count      <= '0;
      end else begin
         if (w_doPush) begin
            r_entryX[r_wrPtr]     <= i_push_x;
            r_entryY[r_wrPtr]     <= i_push_y;
            r_entryValid[r_wrPtr] <= 1'b1;
            r_wrPtr               <= r_wrPtr + AW'(1);
         end
         if (w_doPop) begin
            r_entryValid[r_rdPtr] <= 1'b0;
            r_rdPtr               <= r_rdPtr + AW'(1);
         end
         case ({w_doPush, w_doPop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Look for the queried cell among the entries still waiting to commit
   always_comb begin
      w_match = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (r_entryValid[i] && (r_entryX[i] == i_match_x) && (r_entryY[i] == i_match_y)) begin
            w_match = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wall_map.sv
// Wall bitmap of the game field. Loads the fixed layout on each entry into
// the game state, answers VGA and game-logic reads, and commits queued
// destroy writes only while the VGA stage is outside the active lines.
module wall_map
   import game_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [1:0]         i_state,
   input  logic               i_vga_buzy,
   input  logic [COORD_W-1:0] i_vga_x,
   input  logic [COORD_W-1:0] i_vga_y,
   output logic               o_vga_is_wall,
   input  logic               i_req_valid,
   input  logic               i_req_write,
   input  logic [COORD_W-1:0] i_req_x,
   input  logic [COORD_W-1:0] i_req_y,
   output logic               o_req_ready,
   output logic               o_rsp_valid,
   output logic               o_rsp_is_wall,
   output logic               o_map_ready
);

   map_state_t         r_mapState;
   map_state_t         w_nextState;
   logic [1:0]         r_prevState;
   logic [COORD_W-1:0] r_initX;
   logic [COORD_W-1:0] r_initY;
   logic [MAP_W-1:0]   r_map [MAP_H];
   logic               r_vgaIsWall;
   logic               r_rspValid;
   logic               r_rspIsWall;

   logic               w_inGame;
   logic               w_initLast;
   logic               w_reqReady;
   logic               w_readAccept;
   logic               w_writeAccept;
   logic               w_pop;
   logic               w_flush;
   logic               w_fifoFull;
   logic               w_fifoEmpty;
   logic [COORD_W-1:0] w_popX;
   logic [COORD_W-1:0] w_popY;
   logic               w_match;

   assign w_inGame      = (i_state == ST_GAME);
   assign w_initLast    = (r_initX == X_LAST) && (r_initY == Y_LAST);
   assign w_reqReady    = (r_mapState == MAP_RUN) & ~w_fifoFull;
   assign w_readAccept  = i_req_valid & w_reqReady & ~i_req_write;
   assign w_writeAccept = i_req_valid & w_reqReady & i_req_write;
   assign w_pop         = (r_mapState == MAP_RUN) & ~i_vga_buzy & ~w_fifoEmpty;
   assign w_flush       = (r_mapState != MAP_RUN);

   assign o_req_ready   = w_reqReady;
   assign o_map_ready   = (r_mapState == MAP_RUN);
   assign o_vga_is_wall = r_vgaIsWall;
   assign o_rsp_valid   = r_rspValid;
   assign o_rsp_is_wall = r_rspIsWall;

   wall_write_fifo #(.DEPTH(WQ_DEPTH)) u_writeQueue (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_flush   (w_flush),
      .i_push    (w_writeAccept),
      .i_push_x  (i_req_x),
      .i_push_y  (i_req_y),
      .i_pop     (w_pop),
      .o_pop_x   (w_popX),
      .o_pop_y   (w_popY),
      .o_full    (w_fifoFull),
      .o_empty   (w_fifoEmpty),
      .i_match_x (i_req_x),
      .i_match_y (i_req_y),
      .o_match   (w_match)
   );

   // Map controller state and previous game state for entry-edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mapState  <= MAP_IDLE;
         r_prevState <= ST_START;
      end else begin
         r_mapState  <= w_nextState;
         r_prevState <= i_state;
      end
   end

   // Next state: load on entry into game, run until the game state is left
   always_comb begin
      w_nextState = r_mapState;
      case (r_mapState)
         MAP_IDLE: if (w_inGame && (r_prevState != ST_GAME)) w_nextState = MAP_INIT;
         MAP_INIT: begin
            if (!w_inGame)       w_nextState = MAP_IDLE;
            else if (w_initLast) w_nextState = MAP_RUN;
         end
         MAP_RUN:  if (!w_inGame) w_nextState = MAP_IDLE;
         default:  w_nextState = MAP_IDLE;
      endcase
   end

   // Raster-order cell counter for the layout load, parked at 0 outside INIT
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_initX <= '0;
         r_initY <= '0;
      end else if (r_mapState != MAP_INIT) begin
         r_initX <= '0;
         r_initY <= '0;
      end else begin
         r_initX <= r_initX + COORD_W'(1);
         if (r_initX == X_LAST) r_initY <= r_initY + COORD_W'(1);
      end
   end

   // Bitmap write port: layout load during INIT, committed destroys during RUN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < MAP_H; i++) r_map[i] <= '0;
      end else if (r_mapState == MAP_INIT) begin
         r_map[r_initY][r_initX] <= is_layout_wall(r_initX, r_initY);
      end else if (w_pop && !is_border(w_popX, w_popY) && (w_popY < Y_LIMIT)) begin
         r_map[w_popY][w_popX] <= 1'b0;
      end
   end

   // VGA read port: committed map only, rows below the field read as wall
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vgaIsWall <= 1'b0;
      end else if (r_mapState == MAP_INIT) begin
         r_vgaIsWall <= 1'b0;
      end else if (i_vga_y >= Y_LIMIT) begin
         r_vgaIsWall <= 1'b1;
      end else begin
         r_vgaIsWall <= r_map[i_vga_y][i_vga_x];
      end
   end

   // Game read port: pending destroys already count as cleared
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rspValid  <= 1'b0;
         r_rspIsWall <= 1'b0;
      end else begin
         r_rspValid <= w_readAccept;
         if (!w_readAccept)            r_rspIsWall <= 1'b0;
         else if (i_req_y >= Y_LIMIT)  r_rspIsWall <= 1'b1;
         else                          r_rspIsWall <= r_map[i_req_y][i_req_x] & ~w_match;
      end
   end

endmodule

// File: tb/tb_wall_map.sv
// Directed bench for wall_map: layout load, both read ports, queued
// destroys committed during blanking, queue limits and reset behaviour.
module tb_wall_map;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] i_state;
   logic       i_vga_buzy;
   logic [5:0] i_vga_x;
   logic [5:0] i_vga_y;
   logic       o_vga_is_wall;
   logic       i_req_valid;
   logic       i_req_write;
   logic [5:0] i_req_x;
   logic [5:0] i_req_y;
   logic       o_req_ready;
   logic       o_rsp_valid;
   logic       o_rsp_is_wall;
   logic       o_map_ready;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [5:0] x;
      logic [5:0] y;
      logic       expWall;
      string      name;
   } cellVec_t;

   cellVec_t layoutVecs [15];

   wall_map dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_state       (i_state),
      .i_vga_buzy    (i_vga_buzy),
      .i_vga_x       (i_vga_x),
      .i_vga_y       (i_vga_y),
      .o_vga_is_wall (o_vga_is_wall),
      .i_req_valid   (i_req_valid),
      .i_req_write   (i_req_write),
      .i_req_x       (i_req_x),
      .i_req_y       (i_req_y),
      .o_req_ready   (o_req_ready),
      .o_rsp_valid   (o_rsp_valid),
      .o_rsp_is_wall (o_rsp_is_wall),
      .o_map_ready   (o_map_ready)
   );

   // Free-running 100 MHz clock
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic actual, input logic expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0b expected %0b", name, actual, expected);
      end
   endtask

   task automatic checkCount(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   // One clock, then settle so outputs are sampled away from the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic vgaCheck(input string name, input logic [5:0] x, input logic [5:0] y,
                           input logic expWall);
      i_vga_x = x;
      i_vga_y = y;
      tick();
      checkOutput(name, o_vga_is_wall, expWall);
   endtask

   task automatic gameRead(input string name, input logic [5:0] x, input logic [5:0] y,
                           input logic expWall);
      i_req_valid = 1'b1;
      i_req_write = 1'b0;
      i_req_x     = x;
      i_req_y     = y;
      checkOutput({name, " ready"}, o_req_ready, 1'b1);
      tick();
      i_req_valid = 1'b0;
      checkOutput({name, " rsp_valid"}, o_rsp_valid, 1'b1);
      checkOutput(name, o_rsp_is_wall, expWall);
   endtask

   task automatic gameWrite(input string name, input logic [5:0] x, input logic [5:0] y);
      i_req_valid = 1'b1;
      i_req_write = 1'b1;
      i_req_x     = x;
      i_req_y     = y;
      checkOutput({name, " ready"}, o_req_ready, 1'b1);
      tick();
      i_req_valid = 1'b0;
      i_req_write = 1'b0;
   endtask

   // Bounded wait for the layout load to finish
   task automatic waitMapReady(input string name, output int cycles);
      cycles = 0;
      while (!o_map_ready && cycles < 4000) begin
         tick();
         cycles++;
      end
      checkOutput({name, " map_ready"}, o_map_ready, 1'b1);
   endtask

   // Check every layout vector through both read ports
   task automatic applyStimulus();
      for (int i = 0; i < 15; i++) begin
         vgaCheck({"vga ", layoutVecs[i].name}, layoutVecs[i].x, layoutVecs[i].y,
                  layoutVecs[i].expWall);
         gameRead({"game ", layoutVecs[i].name}, layoutVecs[i].x, layoutVecs[i].y,
                  layoutVecs[i].expWall);
      end
   endtask

   initial begin
      int cycles;

      layoutVecs[0]  = '{6'd0,  6'd5,  1'b1, "left column (0,5)"};
      layoutVecs[1]  = '{6'd1,  6'd1,  1'b0, "open (1,1)"};
      layoutVecs[2]  = '{6'd4,  6'd2,  1'b1, "pillar top (4,2)"};
      layoutVecs[3]  = '{6'd4,  6'd6,  1'b0, "below pillar (4,6)"};
      layoutVecs[4]  = '{6'd4,  6'd5,  1'b1, "pillar bottom (4,5)"};
      layoutVecs[5]  = '{6'd12, 6'd3,  1'b1, "pillar (12,3)"};
      layoutVecs[6]  = '{6'd5,  6'd3,  1'b0, "beside pillar (5,3)"};
      layoutVecs[7]  = '{6'd63, 6'd20, 1'b1, "right column (63,20)"};
      layoutVecs[8]  = '{6'd30, 6'd43, 1'b1, "bottom row (30,43)"};
      layoutVecs[9]  = '{6'd30, 6'd44, 1'b1, "first row off map (30,44)"};
      layoutVecs[10] = '{6'd30, 6'd63, 1'b1, "last row off map (30,63)"};
      layoutVecs[11] = '{6'd10, 6'd10, 1'b0, "open (10,10)"};
      layoutVecs[12] = '{6'd12, 6'd10, 1'b1, "pillar (12,10)"};
      layoutVecs[13] = '{6'd12, 6'd14, 1'b0, "pillar gap (12,14)"};
      layoutVecs[14] = '{6'd0,  6'd0,  1'b1, "corner (0,0)"};

      rst_n       = 1'b0;
      i_state     = 2'b00;
      i_vga_buzy  = 1'b0;
      i_vga_x     = 6'd0;
      i_vga_y     = 6'd0;
      i_req_valid = 1'b0;
      i_req_write = 1'b0;
      i_req_x     = 6'd0;
      i_req_y     = 6'd0;

      // ---- 1: reset values, layout load timing and contents
      tick();
      tick();
      checkOutput("reset vga_is_wall", o_vga_is_wall, 1'b0);
      checkOutput("reset req_ready", o_req_ready, 1'b0);
      checkOutput("reset rsp_valid", o_rsp_valid, 1'b0);
      checkOutput("reset rsp_is_wall", o_rsp_is_wall, 1'b0);
      checkOutput("reset map_ready", o_map_ready, 1'b0);
      rst_n = 1'b1;
      tick();
      i_state = 2'b01;
      i_vga_x = 6'd0;
      i_vga_y = 6'd0;
      tick();
      checkOutput("init req_ready", o_req_ready, 1'b0);
      checkOutput("init map_ready", o_map_ready, 1'b0);
      waitMapReady("first load", cycles);
      checkCount("load cycles", cycles, 2816);
      checkOutput("vga blanked during init", o_vga_is_wall, 1'b0);
      applyStimulus();
      tick();
      checkOutput("rsp_valid pulse", o_rsp_valid, 1'b0);

      // ---- 2: destroy during active display commits in blanking
      i_vga_buzy = 1'b1;
      gameWrite("write (4,2)", 6'd4, 6'd2);
      gameRead("pending read (4,2)", 6'd4, 6'd2, 1'b0);
      vgaCheck("vga uncommitted (4,2)", 6'd4, 6'd2, 1'b1);
      i_vga_buzy = 1'b0;
      vgaCheck("vga same cycle as pop (4,2)", 6'd4, 6'd2, 1'b1);
      vgaCheck("vga after pop (4,2)", 6'd4, 6'd2, 1'b0);
      gameRead("committed read (4,2)", 6'd4, 6'd2, 1'b0);

      // ---- 3: queue fills, ready drops, drains one per cycle
      i_vga_buzy = 1'b1;
      gameWrite("fill 1 (12,2)", 6'd12, 6'd2);
      gameWrite("fill 2 (12,3)", 6'd12, 6'd3);
      gameWrite("fill 3 (20,4)", 6'd20, 6'd4);
      gameWrite("fill 4 (28,5)", 6'd28, 6'd5);
      checkOutput("full req_ready", o_req_ready, 1'b0);
      i_vga_x    = 6'd28;
      i_vga_y    = 6'd5;
      i_vga_buzy = 1'b0;
      tick();
      checkOutput("ready after first pop", o_req_ready, 1'b1);
      tick();
      tick();
      tick();
      checkOutput("vga (28,5) at fourth pop", o_vga_is_wall, 1'b1);
      tick();
      checkOutput("vga (28,5) after fourth pop", o_vga_is_wall, 1'b0);
      vgaCheck("drained (12,2)", 6'd12, 6'd2, 1'b0);
      vgaCheck("drained (12,3)", 6'd12, 6'd3, 1'b0);
      vgaCheck("drained (20,4)", 6'd20, 6'd4, 1'b0);

      // ---- 4: border and off-map destroys are popped with no effect
      i_vga_buzy = 1'b1;
      gameWrite("write border (0,10)", 6'd0, 6'd10);
      gameWrite("write off map (20,50)", 6'd20, 6'd50);
      gameRead("pending border (0,10)", 6'd0, 6'd10, 1'b0);
      gameRead("pending off map (20,50)", 6'd20, 6'd50, 1'b1);
      i_vga_buzy = 1'b0;
      tick();
      tick();
      tick();
      vgaCheck("vga border kept (0,10)", 6'd0, 6'd10, 1'b1);
      gameRead("game border kept (0,10)", 6'd0, 6'd10, 1'b1);
      gameRead("game off map (20,50)", 6'd20, 6'd50, 1'b1);

      // ---- 5: push and pop in the same cycle keep the count
      i_vga_buzy = 1'b1;
      gameWrite("q (44,2)", 6'd44, 6'd2);
      gameWrite("q (44,3)", 6'd44, 6'd3);
      i_vga_buzy  = 1'b0;
      gameWrite("push during pop (52,2)", 6'd52, 6'd2);
      i_vga_buzy  = 1'b1;
      gameWrite("q (52,3)", 6'd52, 6'd3);
      gameWrite("q (52,4)", 6'd52, 6'd4);
      checkOutput("full after push+pop", o_req_ready, 1'b0);
      i_vga_x    = 6'd52;
      i_vga_y    = 6'd2;
      i_vga_buzy = 1'b0;
      tick();
      checkOutput("order: (52,2) before its pop", o_vga_is_wall, 1'b1);
      tick();
      checkOutput("order: (52,2) at its pop", o_vga_is_wall, 1'b1);
      tick();
      checkOutput("order: (52,2) after its pop", o_vga_is_wall, 1'b0);
      tick();
      vgaCheck("cleared (44,2)", 6'd44, 6'd2, 1'b0);
      vgaCheck("cleared (44,3)", 6'd44, 6'd3, 1'b0);
      vgaCheck("cleared (52,3)", 6'd52, 6'd3, 1'b0);
      vgaCheck("cleared (52,4)", 6'd52, 6'd4, 1'b0);

      // ---- 6: leaving the game keeps the map, reset clears it, re-entry reloads
      i_state = 2'b10;
      tick();
      checkOutput("over map_ready", o_map_ready, 1'b0);
      vgaCheck("retained destroyed (4,2)", 6'd4, 6'd2, 1'b0);
      vgaCheck("retained wall (0,0)", 6'd0, 6'd0, 1'b1);
      i_state = 2'b01;
      for (int i = 0; i < 100; i++) tick();
      rst_n = 1'b0;
      #2;
      checkOutput("mid-init reset map_ready", o_map_ready, 1'b0);
      checkOutput("mid-init reset req_ready", o_req_ready, 1'b0);
      checkOutput("mid-init reset vga", o_vga_is_wall, 1'b0);
      checkOutput("mid-init reset rsp_valid", o_rsp_valid, 1'b0);
      i_state = 2'b00;
      tick();
      rst_n = 1'b1;
      tick();
      vgaCheck("bitmap cleared by reset (0,0)", 6'd0, 6'd0, 1'b0);
      i_state = 2'b01;
      tick();
      waitMapReady("reload after reset", cycles);
      checkCount("reload cycles", cycles, 2816);
      vgaCheck("reloaded (4,2)", 6'd4, 6'd2, 1'b1);
      gameWrite("destroy again (4,2)", 6'd4, 6'd2);
      tick();
      tick();
      vgaCheck("destroyed again (4,2)", 6'd4, 6'd2, 1'b0);
      i_vga_buzy = 1'b1;
      gameWrite("queued at exit (12,2)", 6'd12, 6'd2);
      i_state = 2'b10;
      tick();
      i_state = 2'b01;
      tick();
      i_vga_buzy = 1'b0;
      waitMapReady("re-entry load", cycles);
      vgaCheck("re-entry restores (4,2)", 6'd4, 6'd2, 1'b1);
      gameRead("flushed entry (12,2)", 6'd12, 6'd2, 1'b1);
      tick();
      tick();
      vgaCheck("flushed entry not committed (12,2)", 6'd12, 6'd2, 1'b1);
      gameRead("run read before reset (0,0)", 6'd0, 6'd0, 1'b1);
      rst_n = 1'b0;
      #2;
      checkOutput("run reset vga", o_vga_is_wall, 1'b0);
      checkOutput("run reset rsp_valid", o_rsp_valid, 1'b0);
      checkOutput("run reset rsp_is_wall", o_rsp_is_wall, 1'b0);
      checkOutput("run reset map_ready", o_map_ready, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
